// File: rtl/turn_ctl.sv
// rtl/turn_ctl.sv - two-player artillery turn sequencer: aim timer, shot launch, hit resolution, lives and winner
module turn_ctl #(
    parameter int unsigned TURN_TIME = 30,
    parameter int unsigned LIVES     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sec_tick,
    input  logic       fire,
    input  logic       proj_done,
    input  logic       hit,
    output logic       active_player,
    output logic       next_turn,
    output logic       launch,
    output logic [5:0] turn_time,
    output logic [1:0] lives_p1,
    output logic [1:0] lives_p2,
    output logic       game_over,
    output logic       winner
);

    localparam logic [5:0] TT_LOAD    = 6'(TURN_TIME);
    localparam logic [1:0] LIVES_LOAD = 2'(LIVES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        AIM     = 3'd1,
        FLIGHT  = 3'd2,
        RESOLVE = 3'd3,
        OVER    = 3'd4
    } state_t;

    state_t     state_q;
    logic       active_q;
    logic       next_turn_q;
    logic       launch_q;
    logic [5:0] turn_time_q;
    logic [1:0] lives_p1_q;
    logic [1:0] lives_p2_q;
    logic       game_over_q;
    logic       winner_q;

    // Lives of whoever is being shot at this turn.
    logic [1:0] opp_lives;
    assign opp_lives = active_q ? lives_p1_q : lives_p2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            active_q    <= 1'b0;
            next_turn_q <= 1'b0;
            launch_q    <= 1'b0;
            turn_time_q <= 6'd0;
            lives_p1_q  <= LIVES_LOAD;
            lives_p2_q  <= LIVES_LOAD;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            next_turn_q <= 1'b0;
            launch_q    <= 1'b0;
            case (state_q)
                IDLE, OVER: begin
                    if (start) begin
                        state_q     <= AIM;
                        active_q    <= 1'b0;
                        turn_time_q <= TT_LOAD;
                        lives_p1_q  <= LIVES_LOAD;
                        lives_p2_q  <= LIVES_LOAD;
                        game_over_q <= 1'b0;
                        winner_q    <= 1'b0;
                        next_turn_q <= 1'b1;
                    end
                end
                AIM: begin
                    // A shot released on the final tick still counts.
                    if (fire) begin
                        launch_q <= 1'b1;
                        state_q  <= FLIGHT;
                    end else if (sec_tick) begin
                        if (turn_time_q <= 6'd1) begin
                            turn_time_q <= 6'd0;
                            state_q     <= RESOLVE;
                        end else begin
                            turn_time_q <= turn_time_q - 6'd1;
                        end
                    end
                end
                FLIGHT: begin
                    if (proj_done) begin
                        if (hit) begin
                            if (active_q) begin
                                if (lives_p1_q != 2'd0) lives_p1_q <= lives_p1_q - 2'd1;
                            end else begin
                                if (lives_p2_q != 2'd0) lives_p2_q <= lives_p2_q - 2'd1;
                            end
                        end
                        state_q <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    if (opp_lives == 2'd0) begin
                        state_q     <= OVER;
                        game_over_q <= 1'b1;
                        winner_q    <= active_q;
                    end else begin
                        state_q     <= AIM;
                        active_q    <= ~active_q;
                        turn_time_q <= TT_LOAD;
                        next_turn_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign active_player = active_q;
    assign next_turn     = next_turn_q;
    assign launch        = launch_q;
    assign turn_time     = turn_time_q;
    assign lives_p1      = lives_p1_q;
    assign lives_p2      = lives_p2_q;
    assign game_over     = game_over_q;
    assign winner        = winner_q;

endmodule

// File: tb/tb_turn_ctl.sv
// tb/tb_turn_ctl.sv - scoreboard bench for turn_ctl: expected events queued by stimulus, popped by monitor
module tb_turn_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, sec_tick = 1'b0, fire = 1'b0, proj_done = 1'b0, hit = 1'b0;
    logic       active_player, next_turn, launch, game_over, winner;
    logic [5:0] turn_time;
    logic [1:0] lives_p1, lives_p2;

    turn_ctl #(.TURN_TIME(30), .LIVES(3)) dut (
        .clk(clk), .rst(rst), .start(start), .sec_tick(sec_tick), .fire(fire),
        .proj_done(proj_done), .hit(hit), .active_player(active_player),
        .next_turn(next_turn), .launch(launch), .turn_time(turn_time),
        .lives_p1(lives_p1), .lives_p2(lives_p2), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] K_NT = 2'd0, K_LAUNCH = 2'd1, K_GO = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic       ap;
        logic [5:0] tt;
        logic [1:0] l1;
        logic [1:0] l2;
        logic       go;
        logic       win;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic expect_ev(input logic [1:0] kind, input logic ap, input logic [5:0] tt,
                             input logic [1:0] l1, input logic [1:0] l2,
                             input logic go, input logic win);
        ev_t e;
        e = '{kind: kind, ap: ap, tt: tt, l1: l1, l2: l2, go: go, win: win};
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic cyc(input logic s, input logic t, input logic f, input logic p, input logic h);
        start = s; sec_tick = t; fire = f; proj_done = p; hit = h;
        @(posedge clk); #1;
        start = 0; sec_tick = 0; fire = 0; proj_done = 0; hit = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ap"}, int'(active_player), 0);
        chk({tag, "_nt"}, int'(next_turn), 0);
        chk({tag, "_launch"}, int'(launch), 0);
        chk({tag, "_tt"}, int'(turn_time), 0);
        chk({tag, "_l1"}, int'(lives_p1), 3);
        chk({tag, "_l2"}, int'(lives_p2), 3);
        chk({tag, "_go"}, int'(game_over), 0);
        chk({tag, "_win"}, int'(winner), 0);
    endtask

    // Monitor: every cycle with a pulse or a game_over rise consumes one expected event.
    logic go_prev = 1'b0;
    always @(negedge clk) begin
        ev_t act, exp_e;
        if (launch || next_turn || (game_over && !go_prev)) begin
            act.kind = launch ? K_LAUNCH : (next_turn ? K_NT : K_GO);
            act.ap = active_player; act.tt = turn_time; act.l1 = lives_p1; act.l2 = lives_p2;
            act.go = game_over; act.win = winner;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %h expected none", act);
            end else begin
                exp_e = exp_q.pop_front();
                if (act != exp_e) begin
                    errors++;
                    $display("FAIL event: got kind=%0d ap=%0d tt=%0d l1=%0d l2=%0d go=%0d win=%0d expected kind=%0d ap=%0d tt=%0d l1=%0d l2=%0d go=%0d win=%0d",
                             act.kind, act.ap, act.tt, act.l1, act.l2, act.go, act.win,
                             exp_e.kind, exp_e.ap, exp_e.tt, exp_e.l1, exp_e.l2, exp_e.go, exp_e.win);
                end
            end
        end
        go_prev = game_over;
    end

    initial begin
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);

        // Match start
        expect_ev(K_NT, 0, 30, 3, 3, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle(1);

        // 5 ticks then fire, hit on player 2
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
        chk("tt_after_5", int'(turn_time), 25);
        expect_ev(K_LAUNCH, 0, 25, 3, 3, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("tt_frozen", int'(turn_time), 25);
        expect_ev(K_NT, 1, 30, 3, 2, 0, 0);
        cyc(0, 0, 0, 1, 1);
        chk("lives_p2_hit", int'(lives_p2), 2);
        idle(2);
        chk("ap_toggle", int'(active_player), 1);

        // Start ignored in AIM; player 2 times out
        cyc(1, 0, 0, 0, 0);
        expect_ev(K_NT, 0, 30, 3, 2, 0, 0);
        for (int i = 0; i < 29; i++) cyc(0, 1, 0, 0, 0);
        chk("tt_before_timeout", int'(turn_time), 1);
        cyc(0, 1, 0, 0, 0);
        chk("tt_timeout_zero", int'(turn_time), 0);
        idle(2);

        // Fire coincides with the final tick
        for (int i = 0; i < 29; i++) cyc(0, 1, 0, 0, 0);
        expect_ev(K_LAUNCH, 0, 1, 3, 2, 0, 0);
        cyc(0, 1, 1, 0, 0);
        chk("tt_fire_wins", int'(turn_time), 1);
        expect_ev(K_NT, 1, 30, 3, 2, 0, 0);
        cyc(0, 0, 0, 1, 0);
        idle(2);

        // Player 2 misses, player 1 hits, until player 2 is out
        expect_ev(K_LAUNCH, 1, 30, 3, 2, 0, 0); cyc(0, 0, 1, 0, 0);
        expect_ev(K_NT, 0, 30, 3, 2, 0, 0);     cyc(0, 0, 0, 1, 0); idle(2);
        expect_ev(K_LAUNCH, 0, 30, 3, 2, 0, 0); cyc(0, 0, 1, 0, 0);
        expect_ev(K_NT, 1, 30, 3, 1, 0, 0);     cyc(0, 0, 0, 1, 1); idle(2);
        expect_ev(K_LAUNCH, 1, 30, 3, 1, 0, 0); cyc(0, 0, 1, 0, 0);
        expect_ev(K_NT, 0, 30, 3, 1, 0, 0);     cyc(0, 0, 0, 1, 0); idle(2);
        expect_ev(K_LAUNCH, 0, 30, 3, 1, 0, 0); cyc(0, 0, 1, 0, 0);
        expect_ev(K_GO, 0, 30, 3, 0, 1, 0);     cyc(0, 0, 0, 1, 1); idle(3);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1);
        chk("over_go", int'(game_over), 1);
        chk("over_winner", int'(winner), 0);
        chk("over_tt", int'(turn_time), 30);
        chk("over_l2", int'(lives_p2), 0);

        // Restart from OVER
        expect_ev(K_NT, 0, 30, 3, 3, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("restart_go", int'(game_over), 0);
        idle(1);

        // Asynchronous reset mid-flight
        expect_ev(K_LAUNCH, 0, 30, 3, 3, 0, 0);
        cyc(0, 0, 1, 0, 0);
        idle(1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        cyc(0, 0, 0, 1, 1);
        cyc(0, 1, 1, 0, 0);
        idle(2);
        chk("post_rst_l2", int'(lives_p2), 3);
        chk("post_rst_tt", int'(turn_time), 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
